clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter CHANNELS, 4, number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, 32, divisor and counter width in bits.
REQ-003 Parameter DIV_DEFAULT, 100_000_000, divisor loaded at reset into every channel.
REQ-004 Port clk  input  1  single system clock; all logic on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port en  input  CHANNELS  per-channel count enable.
REQ-007 Port sync  input  1  one-cycle pulse that phase-aligns all channels.
REQ-008 Port cfg_we  input  1  configuration write strobe.
REQ-009 Port cfg_sel  input  max(1,$clog2(CHANNELS))  target channel of the write.
REQ-010 Port cfg_div  input  CNT_W  new divisor D.
REQ-011 Port cfg_mode  input  1  new mode: 0 = square, 1 = pulse.
REQ-012 Port clk_out  output  CHANNELS  registered divided clock per channel.
REQ-013 Port tick  output  CHANNELS  registered one-cycle pulse at each period wrap.
REQ-014 Port cfg_pending  output  CHANNELS  1 while a written config awaits application.

Function
REQ-015 Each channel SHALL hold an active divisor/mode, a shadow divisor/mode, a pending flag and a CNT_W counter cnt.
REQ-016 Effective divisor Deff SHALL be max(D,2); D of 0 or 1 behaves as 2.
REQ-017 On an edge with en[i]=1 and sync=0: if cnt==Deff-1 (wrap) cnt<=0, otherwise cnt<=cnt+1; nxt denotes the value loaded.
REQ-018 tick[i] SHALL be loaded with 1 on a wrap edge, else 0; exactly one cycle high per Deff enabled cycles.
REQ-019 Square mode: clk_out[i] SHALL be loaded with (nxt < Deff/2, integer division); high floor(Deff/2) cycles, low the remainder.
REQ-020 Pulse mode: clk_out[i] SHALL be loaded with (nxt==0), identical to tick[i].
REQ-021 On an edge with en[i]=0 and sync=0: cnt and clk_out[i] SHALL hold, tick[i] SHALL be loaded with 0.
REQ-022 cfg_we=1 with cfg_sel<CHANNELS SHALL write cfg_div/cfg_mode into that channel's shadow and set cfg_pending; cfg_sel>=CHANNELS SHALL be ignored.
REQ-023 A pending shadow SHALL become active at the channel's next wrap edge, or on the next edge with en[i]=0, and cfg_pending SHALL clear on that same edge.
REQ-024 A write in the same cycle as a wrap on that channel SHALL NOT apply at that wrap; it applies at the following wrap (or while disabled).
REQ-025 A second write before application SHALL overwrite the shadow; only the last value is applied.
REQ-026 The divisor/mode used for a wrap decision and output computation SHALL be the active one before the edge.
REQ-027 sync=1 SHALL, on that edge, set every cnt to 0, tick to 0, clk_out to 0, apply every pending shadow and clear cfg_pending, regardless of en.
REQ-028 sync coinciding with a wrap SHALL produce no tick; sync coinciding with cfg_we SHALL apply the pending shadow first, then store the new write as pending.
REQ-029 Counter arithmetic SHALL be CNT_W bits; Deff-1 computed without overflow for D=2^CNT_W-1.

Reset
REQ-030 rst_n=0 SHALL immediately clear cnt, clk_out, tick, cfg_pending on all channels and set active and shadow divisor to DIV_DEFAULT, mode to square.
REQ-031 Reset asserted mid-period SHALL abandon the period; counting restarts from cnt=0 on the first enabled edge after rst_n rises.

Verification
REQ-032 Reset, write ch0 D=4 square, wait pending clear, sync, en[0]=1 -> clk_out[0] 1,0,0,1,1,0,0,1...; tick[0] high on enabled edges 4, 8, 12.
REQ-033 ch1 D=5 square -> clk_out[1] high 2 cycles, low 3; tick[1] period 5; D=1 and D=0 both give period 2.
REQ-034 ch2 D=3 pulse -> clk_out[2] equals tick[2], one cycle high every 3 cycles.
REQ-035 ch0 running D=4, write D=6 mid-period -> cfg_pending[0]=1 until next wrap, then periods of 6; write on wrap cycle -> one more period of 4.
REQ-036 en[0] dropped for 7 cycles mid-period -> cnt, clk_out frozen, tick 0; resumes with remaining count; pending write applies during disable.
REQ-037 Channels at D=4 and D=6 free-running, pulse sync -> both clk_out 0 next cycle, ticks coincide every 12 cycles; rst_n pulse mid-period -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one system clock.
// Each channel has shadowed divisor/mode registers applied at a period boundary.
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int CNT_W       = 32,
  parameter int DIV_DEFAULT = 100_000_000
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [CHANNELS-1:0]                              en,
  input  logic                                             sync,
  input  logic                                             cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_sel,
  input  logic [CNT_W-1:0]                                 cfg_div,
  input  logic                                             cfg_mode,
  output logic [CHANNELS-1:0]                              clk_out,
  output logic [CHANNELS-1:0]                              tick,
  output logic [CHANNELS-1:0]                              cfg_pending
);

  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] act_div_r;
    logic [CNT_W-1:0] shd_div_r;
    logic             act_mode_r;
    logic             shd_mode_r;
    logic             pend_r;
    logic             clk_out_r;
    logic             tick_r;

    logic [CNT_W-1:0] deff_m1_s;
    logic [CNT_W-1:0] half_s;
    logic [CNT_W-1:0] nxt_s;
    logic             wrap_s;
    logic             out_s;
    logic             hit_s;
    logic             apply_s;

    // Effective divisor terms, next count and next output from the active config
    always_comb begin
      if (act_div_r < CNT_W'(2)) begin
        deff_m1_s = CNT_W'(1);
        half_s    = CNT_W'(1);
      end else begin
        deff_m1_s = act_div_r - CNT_W'(1);
        half_s    = act_div_r >> 1;
      end
      // >= keeps a counter left above a freshly shrunk divisor from running away
      wrap_s = (cnt_r >= deff_m1_s);
      if (wrap_s) begin
        nxt_s = {CNT_W{1'b0}};
      end else begin
        nxt_s = cnt_r + CNT_W'(1);
      end
      if (act_mode_r) begin
        out_s = (nxt_s == {CNT_W{1'b0}});
      end else begin
        out_s = (nxt_s < half_s);
      end
      hit_s   = cfg_we && (cfg_sel == SEL_W'(i));
      apply_s = pend_r && (sync || !en[i] || wrap_s);
    end

    // Counter, outputs and shadow/active configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r      <= {CNT_W{1'b0}};
        act_div_r  <= CNT_W'(DIV_DEFAULT);
        shd_div_r  <= CNT_W'(DIV_DEFAULT);
        act_mode_r <= 1'b0;
        shd_mode_r <= 1'b0;
        pend_r     <= 1'b0;
        clk_out_r  <= 1'b0;
        tick_r     <= 1'b0;
      end else begin
        if (sync) begin
          cnt_r     <= {CNT_W{1'b0}};
          clk_out_r <= 1'b0;
          tick_r    <= 1'b0;
        end else if (en[i]) begin
          cnt_r     <= nxt_s;
          clk_out_r <= out_s;
          tick_r    <= wrap_s;
        end else begin
          tick_r    <= 1'b0;
        end

        if (apply_s) begin
          act_div_r  <= shd_div_r;
          act_mode_r <= shd_mode_r;
        end

        // A same-edge write lands after any application, so it stays pending
        if (hit_s) begin
          shd_div_r  <= cfg_div;
          shd_mode_r <= cfg_mode;
          pend_r     <= 1'b1;
        end else if (apply_s) begin
          pend_r     <= 1'b0;
        end
      end
    end

    assign clk_out[i]     = clk_out_r;
    assign tick[i]        = tick_r;
    assign cfg_pending[i] = pend_r;
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: scoreboard against a behavioural model,
// table-driven vectors and hand-written period/phase sequences.
module tb_clk_div_bank;

  localparam int CH   = 3;
  localparam int DDEF = 100_000_000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic          sync = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = 2'd0;
  logic [31:0]   cfg_div = 32'd0;
  logic          cfg_mode = 1'b0;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] cfg_pending;

  clk_div_bank #(.CHANNELS(CH), .CNT_W(32), .DIV_DEFAULT(DDEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_div(cfg_div), .cfg_mode(cfg_mode),
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH-1:0] clk_out;
    logic [CH-1:0] tick;
    logic [CH-1:0] pend;
  } exp_t;

  typedef struct {
    logic [CH-1:0] en;
    logic          we;
    logic [1:0]    sel;
    logic [31:0]   div;
    logic          mode;
    int            reps;
  } vec_t;

  exp_t   exp_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  longint        m_cnt[CH];
  longint        m_act_div[CH];
  longint        m_shd_div[CH];
  logic          m_act_mode[CH];
  logic          m_shd_mode[CH];
  logic [CH-1:0] m_clk;
  logic [CH-1:0] m_tick;
  logic [CH-1:0] m_pend;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_cnt[i] = 0;
      m_act_div[i] = DDEF;
      m_shd_div[i] = DDEF;
      m_act_mode[i] = 1'b0;
      m_shd_mode[i] = 1'b0;
    end
    m_clk = '0;
    m_tick = '0;
    m_pend = '0;
  endtask

  task automatic model_step(input logic [CH-1:0] e, input logic s, input logic we,
                            input logic [1:0] sel, input logic [31:0] d, input logic md);
    for (int i = 0; i < CH; i++) begin
      longint deff;
      longint nxt;
      logic   wrap;
      logic   apply;
      deff = (m_act_div[i] < 2) ? 2 : m_act_div[i];
      apply = 1'b0;
      if (s) begin
        m_cnt[i] = 0;
        m_tick[i] = 1'b0;
        m_clk[i] = 1'b0;
        apply = m_pend[i];
      end else if (e[i]) begin
        wrap = (m_cnt[i] == deff - 1);
        nxt = wrap ? 0 : m_cnt[i] + 1;
        m_tick[i] = wrap;
        m_clk[i] = m_act_mode[i] ? (nxt == 0) : (nxt < deff / 2);
        m_cnt[i] = nxt;
        apply = wrap && m_pend[i];
      end else begin
        m_tick[i] = 1'b0;
        apply = m_pend[i];
      end
      if (apply) begin
        m_act_div[i] = m_shd_div[i];
        m_act_mode[i] = m_shd_mode[i];
        m_pend[i] = 1'b0;
      end
      if (we && int'(sel) == i) begin
        m_shd_div[i] = d;
        m_shd_mode[i] = md;
        m_pend[i] = 1'b1;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock: drive at negedge, push model expectation, compare after posedge
  task automatic cycle(input logic [CH-1:0] e, input logic s, input logic we,
                       input logic [1:0] sel, input logic [31:0] d, input logic md);
    exp_t x;
    @(negedge clk);
    en = e; sync = s; cfg_we = we; cfg_sel = sel; cfg_div = d; cfg_mode = md;
    model_step(e, s, we, sel, d, md);
    x.clk_out = m_clk; x.tick = m_tick; x.pend = m_pend;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    n_vec++;
    if (clk_out !== x.clk_out || tick !== x.tick || cfg_pending !== x.pend) begin
      n_err++;
      $display("FAIL scoreboard t=%0t: clk_out=%b tick=%b pend=%b, expected %b %b %b",
               $time, clk_out, tick, cfg_pending, x.clk_out, x.tick, x.pend);
    end
  endtask

  task automatic idle(input logic [CH-1:0] e);
    cycle(e, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0);
  endtask

  task automatic run_until_cnt(input int ch, input longint val, input logic [CH-1:0] e);
    int n = 0;
    while (m_cnt[ch] != val && n < 64) begin
      idle(e);
      n++;
    end
    if (m_cnt[ch] != val) begin
      n_vec++;
      n_err++;
      $display("FAIL run_until_cnt: ch%0d never reached %0d", ch, val);
    end
  endtask

  task automatic cycles_to_tick(input int ch, input logic [CH-1:0] e, output int n);
    n = 0;
    do begin
      idle(e);
      n++;
    end while (tick[ch] !== 1'b1 && n < 64);
  endtask

  vec_t vecs[9];

  initial begin
    int          n;
    int          hi;
    int          tk;
    int          both;
    int          first;
    logic [11:0] clk_seq;
    logic [11:0] tick_seq;
    logic        held;

    vecs[0] = '{3'b001, 1'b1, 2'd1, 32'd5, 1'b0, 1};
    vecs[1] = '{3'b001, 1'b1, 2'd2, 32'd3, 1'b1, 1};
    vecs[2] = '{3'b001, 1'b0, 2'd0, 32'd0, 1'b0, 1};
    vecs[3] = '{3'b111, 1'b0, 2'd0, 32'd0, 1'b0, 15};
    vecs[4] = '{3'b111, 1'b1, 2'd3, 32'd7, 1'b0, 3};
    vecs[5] = '{3'b111, 1'b1, 2'd1, 32'd1, 1'b0, 12};
    vecs[6] = '{3'b111, 1'b1, 2'd1, 32'd0, 1'b0, 12};
    vecs[7] = '{3'b111, 1'b1, 2'd2, 32'd8, 1'b0, 1};
    vecs[8] = '{3'b111, 1'b1, 2'd2, 32'd3, 1'b1, 9};

    model_reset();
    #3;
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_pending", 32'(cfg_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ch0 D=4 square, applied while disabled, then phase-aligned
    cycle(3'b000, 1'b0, 1'b1, 2'd0, 32'd4, 1'b0);
    idle(3'b000);
    check("pending_cleared", 32'(cfg_pending[0]), 32'd0);
    cycle(3'b000, 1'b1, 1'b0, 2'd0, 32'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      idle(3'b001);
      clk_seq[k] = clk_out[0];
      tick_seq[k] = tick[0];
    end
    check("d4_clk_pattern", 32'(clk_seq), 32'h999);
    check("d4_tick_pattern", 32'(tick_seq), 32'h888);

    // Table-driven vectors
    for (int v = 0; v < 9; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        cycle(vecs[v].en, 1'b0, (r == 0) ? vecs[v].we : 1'b0, vecs[v].sel, vecs[v].div, vecs[v].mode);
      end
      if (v == 3) begin
        hi = 0; tk = 0;
        for (int k = 0; k < 5; k++) begin
          idle(3'b111);
          hi += int'(clk_out[1]);
          tk += int'(tick[1]);
          check("pulse_eq_tick", 32'(clk_out[2]), 32'(tick[2]));
        end
        check("d5_high_cycles", 32'(hi), 32'd2);
        check("d5_ticks", 32'(tk), 32'd1);
      end
      if (v == 6) begin
        tk = 0;
        for (int k = 0; k < 6; k++) begin
          idle(3'b111);
          tk += int'(tick[1]);
        end
        check("d0_ticks", 32'(tk), 32'd3);
      end
    end

    // Mid-period write on ch0 (D=4 -> 6), then a write on a wrap edge
    run_until_cnt(0, 1, 3'b111);
    cycle(3'b111, 1'b0, 1'b1, 2'd0, 32'd6, 1'b0);
    check("pending_mid", 32'(cfg_pending[0]), 32'd1);
    cycles_to_tick(0, 3'b111, n);
    check("old_period_tail", 32'(n), 32'd2);
    check("pending_at_wrap", 32'(cfg_pending[0]), 32'd0);
    cycles_to_tick(0, 3'b111, n);
    check("period_6", 32'(n), 32'd6);
    run_until_cnt(0, 5, 3'b111);
    cycle(3'b111, 1'b0, 1'b1, 2'd0, 32'd4, 1'b0);
    check("wrap_write_tick", 32'(tick[0]), 32'd1);
    cycles_to_tick(0, 3'b111, n);
    check("one_more_6", 32'(n), 32'd6);
    cycles_to_tick(0, 3'b111, n);
    check("then_4", 32'(n), 32'd4);

    // Disable ch0 mid-period for 7 cycles with a write applied while frozen
    run_until_cnt(0, 1, 3'b111);
    held = clk_out[0];
    for (int k = 0; k < 7; k++) begin
      cycle(3'b110, 1'b0, (k == 0), 2'd0, 32'd6, 1'b0);
      check("frozen_clk", 32'(clk_out[0]), 32'(held));
      check("frozen_tick", 32'(tick[0]), 32'd0);
    end
    check("applied_disabled", 32'(cfg_pending[0]), 32'd0);
    cycles_to_tick(0, 3'b111, n);
    check("resume_remaining", 32'(n), 32'd5);

    // D=4 and D=6 free-running, then sync with a coincident write on ch2
    cycle(3'b000, 1'b0, 1'b1, 2'd0, 32'd4, 1'b0);
    cycle(3'b000, 1'b0, 1'b1, 2'd1, 32'd6, 1'b0);
    idle(3'b000);
    for (int k = 0; k < 7; k++) idle(3'b011);
    cycle(3'b011, 1'b1, 1'b1, 2'd2, 32'd9, 1'b0);
    check("sync_clk_out", 32'(clk_out[1:0]), 32'd0);
    check("sync_pending", 32'(cfg_pending), 32'h4);
    both = 0; first = 0;
    for (int k = 1; k <= 24; k++) begin
      idle(3'b011);
      if (tick[0] === 1'b1 && tick[1] === 1'b1) begin
        both++;
        if (first == 0) first = k;
      end
    end
    check("coincide_count", 32'(both), 32'd2);
    check("coincide_first", 32'(first), 32'd12);

    // Asynchronous reset mid-period
    for (int k = 0; k < 3; k++) idle(3'b011);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_clk_out", 32'(clk_out), 32'd0);
    check("async_tick", 32'(tick), 32'd0);
    check("async_pending", 32'(cfg_pending), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) idle(3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
